dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port synchronous data RAM between the processor (port 0) and a debug/loader master (port 1).
- Port 0 has default priority.
- Port 1 has a bounded-wait guarantee, set by a wait counter.
- The block sits between the processor's dmem interface (wren/address_dmem/data/q_dmem) and the RAM instance.
- It issues at most one RAM access per cycle and routes the 1-cycle-latency read data back to the port that issued the read.

---
 rtl/dmem_arbiter.sv | 84 ++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// Port 0 wins by default; port 1 is guaranteed a grant after MAX_WAIT denied cycles.
module dmem_arbiter #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wen,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wen,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic [1:0] rd_pend_q, rd_pend_d;
    logic       p1_win;

    // Port 1 takes the RAM when it is alone or when it has waited long enough.
    always_comb begin
        p1_win = p1_req & (~p0_req | (wait_cnt_q == MAX_WAIT_C));
        p0_gnt = ~reset & p0_req & ~p1_win;
        p1_gnt = ~reset & p1_win;
    end

    always_comb begin
        mem_wen   = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_wen   = p0_wen;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_wen   = p1_wen;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_comb begin
        wait_cnt_d = '0;
        if (p1_req && !p1_gnt) begin
            wait_cnt_d = (wait_cnt_q >= MAX_WAIT_C) ? MAX_WAIT_C : wait_cnt_q + 4'd1;
        end
        rd_pend_d = {p1_gnt & ~p1_wen, p0_gnt & ~p0_wen};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= '0;
            rd_pend_q  <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
        end
    end

    // A read in flight when reset arrives is dropped, not returned.
    always_comb begin
        p0_rvalid = rd_pend_q[0] & ~reset;
        p1_rvalid = rd_pend_q[1] & ~reset;
        p0_rdata  = p0_rvalid ? mem_rdata : '0;
        p1_rdata  = p1_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural RAM and a read-return scoreboard.
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              p0_req, p0_wen, p1_req, p1_wen;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata;
    logic              p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [DATA_W-1:0] p0_rdata, p1_rdata;
    logic              mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clock(clock), .reset(reset),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
    initial for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = '0;
    always @(posedge clock) begin
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        int                port;
        logic [DATA_W-1:0] data;
        int                due;
    } sb_t;

    sb_t               sb[$];
    logic [DATA_W-1:0] shadow [int];
    int                cyc = 0;
    int                n_assert = 0;
    int                n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    logic              mv0, mv1;
    logic [DATA_W-1:0] md0, md1;

    // Every cycle, the rvalid/rdata pair of each port must match the scoreboard.
    always @(negedge clock) begin
        mv0 = 1'b0; mv1 = 1'b0; md0 = '0; md1 = '0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].port == 0) begin mv0 = 1'b1; md0 = sb[0].data; end
            else                 begin mv1 = 1'b1; md1 = sb[0].data; end
            $display("cyc %0d: read return port %0d data %h", cyc, sb[0].port, sb[0].data);
            void'(sb.pop_front());
        end
        n_assert++;
        assert (p0_rvalid === mv0 && p0_rdata === md0) else begin
            n_fail++;
            $error("FAIL p0_ret cyc %0d: observed rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                   cyc, p0_rvalid, p0_rdata, mv0, md0);
        end
        n_assert++;
        assert (p1_rvalid === mv1 && p1_rdata === md1) else begin
            n_fail++;
            $error("FAIL p1_ret cyc %0d: observed rvalid=%b rdata=%h expected rvalid=%b rdata=%h",
                   cyc, p1_rvalid, p1_rdata, mv1, md1);
        end
    end

    task automatic drive(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                         input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        p0_req = r0; p0_wen = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_wen = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic apply(input int port, input logic wen, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        sb_t e;
        if (wen) begin
            shadow[int'(a)] = d;
        end else begin
            e.port = port;
            e.data = shadow.exists(int'(a)) ? shadow[int'(a)] : '0;
            e.due  = cyc + 1;
            sb.push_back(e);
        end
    endtask

    // One cycle: check grants and RAM drive at the negedge, then advance past the posedge.
    task automatic step(input logic eg0, input logic eg1, input string tag);
        logic              ewen;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ewd;
        @(negedge clock);
        ewen = 1'b0; eaddr = '0; ewd = '0;
        if (eg0)      begin ewen = p0_wen; eaddr = p0_addr; ewd = p0_wdata; end
        else if (eg1) begin ewen = p1_wen; eaddr = p1_addr; ewd = p1_wdata; end
        n_assert++;
        assert (p0_gnt === eg0 && p1_gnt === eg1) else begin
            n_fail++;
            $error("FAIL %s gnt cyc %0d: observed p0=%b p1=%b expected p0=%b p1=%b",
                   tag, cyc, p0_gnt, p1_gnt, eg0, eg1);
        end
        n_assert++;
        assert (mem_wen === ewen && mem_addr === eaddr && mem_wdata === ewd) else begin
            n_fail++;
            $error("FAIL %s mem cyc %0d: observed wen=%b addr=%h wdata=%h expected wen=%b addr=%h wdata=%h",
                   tag, cyc, mem_wen, mem_addr, mem_wdata, ewen, eaddr, ewd);
        end
        if (eg0) apply(0, p0_wen, p0_addr, p0_wdata);
        if (eg1) apply(1, p1_wen, p1_addr, p1_wdata);
        $display("cyc %0d: %s req=%b%b gnt=%b%b mem wen=%b addr=%h", cyc, tag,
                 p0_req, p1_req, p0_gnt, p1_gnt, mem_wen, mem_addr);
        @(posedge clock);
        #1;
    endtask

    task automatic check_wait(input logic [3:0] exp, input string tag);
        n_assert++;
        assert (dut.wait_cnt_q === exp) else begin
            n_fail++;
            $error("FAIL %s wait_cnt: observed %0d expected %0d", tag, dut.wait_cnt_q, exp);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 12'd3, '0, 1'b1, 1'b0, 12'd4, '0);
        step(1'b0, 1'b0, "reset_req");
        check_wait(4'd0, "reset");
        reset = 1'b0;

        // Port 0 write then read-after-write of the same word.
        drive(1'b1, 1'b1, 12'd5, 32'h1234, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "p0_wr5");
        drive(1'b1, 1'b0, 12'd5, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "p0_rd5");
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, "idle");

        // Preload via port 1, then simultaneous reads.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'd1, 32'h1111_0001);
        step(1'b0, 1'b1, "p1_wr1");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 12'd2, 32'h2222_0002);
        step(1'b0, 1'b1, "p1_wr2");
        drive(1'b1, 1'b0, 12'd1, '0, 1'b1, 1'b0, 12'd2, '0);
        step(1'b1, 1'b0, "both_rd");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'd2, '0);
        step(1'b0, 1'b1, "p1_rd2");
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, "idle");

        // Starvation bound: p1 wins exactly on the fifth contended cycle.
        drive(1'b1, 1'b0, 12'd10, '0, 1'b1, 1'b1, 12'd11, 32'h0000_BEEF);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "starve");
        check_wait(4'd4, "starve_max");
        step(1'b0, 1'b1, "p1_wins");
        drive(1'b1, 1'b0, 12'd11, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "p0_regrant");
        check_wait(4'd0, "after_win");

        // Alternating back-to-back reads.
        drive(1'b1, 1'b1, 12'd7, 32'd70, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "wr7");
        drive(1'b1, 1'b1, 12'd8, 32'd80, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "wr8");
        drive(1'b1, 1'b1, 12'd9, 32'd90, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "wr9");
        drive(1'b1, 1'b0, 12'd7, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "alt_rd7");
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'd8, '0);
        step(1'b0, 1'b1, "alt_rd8");
        drive(1'b1, 1'b0, 12'd9, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "alt_rd9");

        // Reset with a port 1 read in flight: its return must be dropped.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 12'd8, '0);
        step(1'b0, 1'b1, "p1_rd_pre_rst");
        void'(sb.pop_back());
        reset = 1'b1;
        drive(1'b1, 1'b0, 12'd7, '0, 1'b1, 1'b0, 12'd9, '0);
        step(1'b0, 1'b0, "mid_reset");
        reset = 1'b0;
        check_wait(4'd0, "post_reset");
        drive(1'b1, 1'b0, 12'd7, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "first_after_rst");

        // p1 drops its request at wait_cnt=3, then re-raises: counter restarts.
        drive(1'b1, 1'b0, 12'd9, '0, 1'b1, 1'b0, 12'd2, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "wait_up");
        check_wait(4'd3, "wait3");
        drive(1'b1, 1'b0, 12'd9, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, 1'b0, "p1_drop");
        check_wait(4'd0, "dropped");
        drive(1'b1, 1'b0, 12'd9, '0, 1'b1, 1'b0, 12'd2, '0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, "rewait");
        step(1'b0, 1'b1, "p1_wins2");
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, "idle");
        step(1'b0, 1'b0, "idle");

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain: observed %0d pending reads expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
